// File: rtl/mdu.sv
// Multiply/divide unit for the EXE stage: owns HI/LO, single-cycle MULT/MULTU/MTHI/MTLO,
// and a 32-step restoring divider that stalls the pipeline while it runs.
module mdu #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  alucontrol,
  input  logic        valid,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [7:0] OpMult  = 8'b00011000;
  localparam logic [7:0] OpMultu = 8'b00011001;
  localparam logic [7:0] OpDiv   = 8'b00011010;
  localparam logic [7:0] OpDivu  = 8'b00011011;
  localparam logic [7:0] OpMthi  = 8'b00010001;
  localparam logic [7:0] OpMtlo  = 8'b00010011;

  localparam logic [1:0] StateIdle = 2'd0;
  localparam logic [1:0] StateBusy = 2'd1;
  localparam logic [1:0] StateDone = 2'd2;

  localparam logic [4:0] LastCnt = 5'(DIV_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] divisor_q, divisor_d;
  logic        qNeg_q, qNeg_d;
  logic        rNeg_q, rNeg_d;

  logic signed [63:0] prodSigned;
  logic        [63:0] prodUnsigned;
  logic        [32:0] shifted;
  logic               fits;
  logic        [31:0] nextRem;
  logic               isSigned;

  assign prodSigned   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prodUnsigned = {32'b0, a} * {32'b0, b};
  assign isSigned     = (alucontrol == OpDiv);

  // Restoring step: the remainder never exceeds the divisor, so 33 bits hold the shifted value
  // and the low 32 bits of the difference are exact whenever the subtraction is taken.
  assign shifted = {rem_q, quo_q[31]};
  assign fits    = (shifted >= {1'b0, divisor_q});
  assign nextRem = fits ? (shifted[31:0] - divisor_q) : shifted[31:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    qNeg_d    = qNeg_q;
    rNeg_d    = rNeg_q;
    stall_o   = 1'b0;

    if (flush) begin
      state_d = StateIdle;
    end else begin
      case (state_q)
        StateIdle: begin
          if (valid) begin
            case (alucontrol)
              OpMult:  {hi_d, lo_d} = prodSigned;
              OpMultu: {hi_d, lo_d} = prodUnsigned;
              OpMthi:  hi_d = a;
              OpMtlo:  lo_d = a;
              OpDiv, OpDivu: begin
                stall_o = 1'b1;
                // Divide by zero skips the iterations with the architectural preset result.
                if (b == 32'd0) begin
                  quo_d   = 32'hFFFF_FFFF;
                  rem_d   = a;
                  qNeg_d  = 1'b0;
                  rNeg_d  = 1'b0;
                  state_d = StateDone;
                end else begin
                  quo_d     = (isSigned && a[31]) ? -a : a;
                  divisor_d = (isSigned && b[31]) ? -b : b;
                  rem_d     = 32'd0;
                  qNeg_d    = isSigned && (a[31] ^ b[31]);
                  rNeg_d    = isSigned && a[31];
                  cnt_d     = 5'd0;
                  state_d   = StateBusy;
                end
              end
              default: ;
            endcase
          end
        end
        StateBusy: begin
          stall_o = 1'b1;
          rem_d   = nextRem;
          quo_d   = {quo_q[30:0], fits};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == LastCnt) begin
            state_d = StateDone;
          end
        end
        StateDone: begin
          lo_d    = qNeg_q ? -quo_q : quo_q;
          hi_d    = rNeg_q ? -rem_q : rem_q;
          state_d = StateIdle;
        end
        default: state_d = StateIdle;
      endcase
    end

    // Keep the pipeline free while reset is held, even if a divide sits on the inputs.
    if (!resetn) begin
      stall_o = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StateIdle;
      cnt_q     <= 5'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      divisor_q <= 32'd0;
      qNeg_q    <= 1'b0;
      rNeg_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      qNeg_q    <= qNeg_d;
      rNeg_q    <= rNeg_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed and random MULT/DIV/MT* traffic against an
// arithmetic reference model, plus flush, asynchronous reset and back-to-back scenarios.
module tb_mdu;

  localparam logic [7:0] OpMult  = 8'b00011000;
  localparam logic [7:0] OpMultu = 8'b00011001;
  localparam logic [7:0] OpDiv   = 8'b00011010;
  localparam logic [7:0] OpDivu  = 8'b00011011;
  localparam logic [7:0] OpMthi  = 8'b00010001;
  localparam logic [7:0] OpMtlo  = 8'b00010011;
  localparam logic [7:0] OpMfhi  = 8'b00010000;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  alucontrol;
  logic        valid;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] modelHi = 32'd0;
  logic [31:0] modelLo = 32'd0;

  mdu dut (
    .clk        (clk),
    .resetn     (resetn),
    .alucontrol (alucontrol),
    .valid      (valid),
    .flush      (flush),
    .a          (a),
    .b          (b),
    .stall_o    (stall_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Architectural division result, straight from the ISA definition.
  function automatic void refDiv(input logic [7:0] op, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] q, output logic [31:0] r);
    longint lx, ly;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (op == OpDiv) begin
      lx = longint'($signed(x));
      ly = longint'($signed(y));
      q  = 32'(lx / ly);
      r  = 32'(lx % ly);
    end else begin
      lx = longint'({32'b0, x});
      ly = longint'({32'b0, y});
      q  = 32'(lx / ly);
      r  = 32'(lx % ly);
    end
  endfunction

  function automatic logic [63:0] refMul(input logic [7:0] op, input logic [31:0] x, input logic [31:0] y);
    if (op == OpMult) return 64'(longint'($signed(x)) * longint'($signed(y)));
    return {32'b0, x} * {32'b0, y};
  endfunction

  task automatic drive(input logic [7:0] op, input logic v, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    alucontrol = op;
    valid      = v;
    a          = x;
    b          = y;
    flush      = 1'b0;
  endtask

  // Issues a divide, holds it on the inputs while stalled, returns after the result edge.
  task automatic runDiv(input logic [7:0] op, input logic [31:0] x, input logic [31:0] y,
                        output int stallCycles, output bit timedOut);
    bit done;
    drive(op, 1'b1, x, y);
    stallCycles = 0;
    done        = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (!stall_o) begin
        done = 1'b1;
      end else begin
        stallCycles++;
        @(negedge clk);
      end
    end
    timedOut = !done;
    if (done) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    #12;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stall_o); end
    checks++; if (hi_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 0", hi_o); end
    checks++; if (lo_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 0", lo_o); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_mult;
    logic [7:0]  ops [5];
    logic [7:0]  op;
    logic        v;
    logic [31:0] x, y;
    logic [63:0] p;
    ops = '{OpMult, OpMultu, OpMthi, OpMtlo, 8'h20};

    drive(OpMult, 1'b1, 32'hFFFF_FFFE, 32'd3);
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL mult_stall: got %b expected 0", stall_o); end
    @(posedge clk); #1;
    checks++; if ({hi_o, lo_o} !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("[TB] FAIL mult_signed: got %h_%h expected ffffffff_fffffffa", hi_o, lo_o); end
    drive(OpMultu, 1'b1, 32'hFFFF_FFFE, 32'd3);
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL multu_stall: got %b expected 0", stall_o); end
    @(posedge clk); #1;
    checks++; if ({hi_o, lo_o} !== 64'h0000_0002_FFFF_FFFA) begin errors++; $display("[TB] FAIL mult_unsigned: got %h_%h expected 00000002_fffffffa", hi_o, lo_o); end
    {modelHi, modelLo} = {hi_o, lo_o} === 64'h0000_0002_FFFF_FFFA ? {hi_o, lo_o} : 64'h0000_0002_FFFF_FFFA;

    for (int i = 0; i < 16; i++) begin
      op = ops[$urandom_range(0, 4)];
      v  = ($urandom_range(0, 3) != 0);
      x  = $urandom;
      y  = $urandom;
      drive(op, v, x, y);
      #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL rand_mult_stall[%0d]: got %b expected 0", i, stall_o); end
      if (v) begin
        if (op == OpMult || op == OpMultu) begin
          p = refMul(op, x, y);
          modelHi = p[63:32];
          modelLo = p[31:0];
        end else if (op == OpMthi) begin
          modelHi = x;
        end else if (op == OpMtlo) begin
          modelLo = x;
        end
      end
      @(posedge clk); #1;
      checks++; if ({hi_o, lo_o} !== {modelHi, modelLo}) begin errors++; $display("[TB] FAIL rand_mult[%0d] op=%h v=%b: got %h_%h expected %h_%h", i, op, v, hi_o, lo_o, modelHi, modelLo); end
    end
  endtask

  task automatic test_div_directed;
    logic [7:0]  ops [6];
    logic [31:0] xs [6];
    logic [31:0] ys [6];
    logic [31:0] qs [6];
    logic [31:0] rs [6];
    int          st [6];
    int          stalls;
    bit          timedOut;
    ops = '{OpDivu, OpDiv, OpDiv, OpDiv, OpDiv, OpDivu};
    xs  = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'd7, 32'hFFFF_FFFF};
    ys  = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE, 32'd1};
    qs  = '{32'd14, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    rs  = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'd5, 32'd1, 32'd0};
    st  = '{33, 33, 33, 1, 33, 33};
    for (int i = 0; i < 6; i++) begin
      runDiv(ops[i], xs[i], ys[i], stalls, timedOut);
      checks++; if (timedOut) begin errors++; $display("[TB] FAIL div_dir_timeout[%0d]: got no DONE expected stall release", i); end
      checks++; if (stalls != st[i]) begin errors++; $display("[TB] FAIL div_dir_stalls[%0d]: got %0d expected %0d", i, stalls, st[i]); end
      checks++; if (lo_o !== qs[i]) begin errors++; $display("[TB] FAIL div_dir_lo[%0d]: got %h expected %h", i, lo_o, qs[i]); end
      checks++; if (hi_o !== rs[i]) begin errors++; $display("[TB] FAIL div_dir_hi[%0d]: got %h expected %h", i, hi_o, rs[i]); end
      modelLo = qs[i];
      modelHi = rs[i];
    end
    drive(8'h00, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_div_random;
    logic [7:0]  op;
    logic [31:0] x, y, q, r;
    int          stalls;
    bit          timedOut;
    for (int i = 0; i < 10; i++) begin
      op = ($urandom_range(0, 1) != 0) ? OpDiv : OpDivu;
      x  = $urandom;
      case ($urandom_range(0, 4))
        0:       y = 32'd0;
        1:       y = $urandom >> $urandom_range(16, 31);
        default: y = $urandom >> $urandom_range(0, 31);
      endcase
      if (y == 32'd0 && $urandom_range(0, 1) == 0) y = 32'hFFFF_FFFF;
      refDiv(op, x, y, q, r);
      runDiv(op, x, y, stalls, timedOut);
      checks++; if (timedOut) begin errors++; $display("[TB] FAIL div_rand_timeout[%0d]: got no DONE expected stall release", i); end
      checks++; if (stalls != ((y == 32'd0) ? 1 : 33)) begin errors++; $display("[TB] FAIL div_rand_stalls[%0d]: got %0d expected %0d", i, stalls, (y == 32'd0) ? 1 : 33); end
      checks++; if ({hi_o, lo_o} !== {r, q}) begin errors++; $display("[TB] FAIL div_rand[%0d] op=%h a=%h b=%h: got hi=%h lo=%h expected hi=%h lo=%h", i, op, x, y, hi_o, lo_o, r, q); end
      modelHi = r;
      modelLo = q;
    end
    drive(8'h00, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_flush;
    drive(OpMthi, 1'b1, 32'h1234_5678, 32'd0);
    drive(OpMtlo, 1'b1, 32'hCAFE_F00D, 32'd0);
    @(posedge clk); #1;
    checks++; if ({hi_o, lo_o} !== 64'h1234_5678_CAFE_F00D) begin errors++; $display("[TB] FAIL flush_preload: got %h_%h expected 12345678_cafef00d", hi_o, lo_o); end
    modelHi = 32'h1234_5678;
    modelLo = 32'hCAFE_F00D;

    // A flushed MTHI in IDLE must not write.
    drive(OpMthi, 1'b1, 32'hAAAA_AAAA, 32'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    checks++; if (hi_o !== modelHi) begin errors++; $display("[TB] FAIL flush_mthi: got %h expected %h", hi_o, modelHi); end

    drive(OpDivu, 1'b1, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_stall: got %b expected 0", stall_o); end
    drive(8'h00, 1'b0, 32'd0, 32'd0);
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle_stall: got %b expected 0", stall_o); end
    checks++; if ({hi_o, lo_o} !== {modelHi, modelLo}) begin errors++; $display("[TB] FAIL flush_hilo: got %h_%h expected %h_%h", hi_o, lo_o, modelHi, modelLo); end
    repeat (40) @(negedge clk);
    #1;
    checks++; if ({stall_o, hi_o, lo_o} !== {1'b0, modelHi, modelLo}) begin errors++; $display("[TB] FAIL flush_later: got stall=%b %h_%h expected stall=0 %h_%h", stall_o, hi_o, lo_o, modelHi, modelLo); end
  endtask

  task automatic test_reset_mid;
    drive(OpDivu, 1'b1, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 1", stall_o); end
    #1;
    resetn = 1'b0;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_stall: got %b expected 0", stall_o); end
    checks++; if ({hi_o, lo_o} !== 64'd0) begin errors++; $display("[TB] FAIL rstmid_hilo: got %h_%h expected 0_0", hi_o, lo_o); end
    modelHi = 32'd0;
    modelLo = 32'd0;
    @(negedge clk);
    valid  = 1'b0;
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({stall_o, hi_o, lo_o} !== 65'd0) begin errors++; $display("[TB] FAIL rstmid_after: got stall=%b %h_%h expected stall=0 0_0", stall_o, hi_o, lo_o); end
  endtask

  task automatic test_back_to_back;
    int stalls;
    bit timedOut;
    runDiv(OpDivu, 32'd1000, 32'd9, stalls, timedOut);
    checks++; if (timedOut || stalls != 33) begin errors++; $display("[TB] FAIL b2b_div1: got stalls=%0d timeout=%b expected 33", stalls, timedOut); end
    drive(OpMfhi, 1'b1, 32'd0, 32'd0);
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_mfhi_stall: got %b expected 0", stall_o); end
    @(posedge clk); #1;
    checks++; if ({hi_o, lo_o} !== {32'd1, 32'd111}) begin errors++; $display("[TB] FAIL b2b_mfhi: got %h_%h expected 00000001_0000006f", hi_o, lo_o); end

    runDiv(OpDivu, 32'd1000, 32'd9, stalls, timedOut);
    checks++; if (timedOut || stalls != 33) begin errors++; $display("[TB] FAIL b2b_div2: got stalls=%0d timeout=%b expected 33", stalls, timedOut); end
    drive(OpMtlo, 1'b1, 32'hDEAD_BEEF, 32'd0);
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_mtlo_stall: got %b expected 0", stall_o); end
    @(posedge clk); #1;
    checks++; if ({hi_o, lo_o} !== {32'd1, 32'hDEAD_BEEF}) begin errors++; $display("[TB] FAIL b2b_mtlo: got %h_%h expected 00000001_deadbeef", hi_o, lo_o); end

    drive(OpDiv, 1'b0, 32'd50, 32'd5);
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL bubble_div_stall: got %b expected 0", stall_o); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({stall_o, hi_o, lo_o} !== {1'b0, 32'd1, 32'hDEAD_BEEF}) begin errors++; $display("[TB] FAIL bubble_div: got stall=%b %h_%h expected stall=0 00000001_deadbeef", stall_o, hi_o, lo_o); end
    drive(8'h00, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    resetn     = 1'b0;
    alucontrol = 8'h00;
    valid      = 1'b0;
    flush      = 1'b0;
    a          = 32'd0;
    b          = 32'd0;
    $display("[TB] starting mdu bench");
    test_reset;
    test_mult;
    test_div_directed;
    test_div_random;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
